// File: rtl/transpose_pkg.sv
// Shared types and sizing helpers for the transpose skew buffer.
package transpose_pkg;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StDrain = 1'b1
  } state_e;

  // Width of the drain step counter, which spans 0..depth+channels-2.
  function automatic int unsigned step_width(input int unsigned depth,
                                             input int unsigned channels);
    return $clog2(depth + channels - 1);
  endfunction

endpackage

// File: rtl/transpose_bank.sv
// Parallel-load CHANNELS x DEPTH word register bank with asynchronous clear.
module transpose_bank
  import transpose_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned BITS     = 64,
  parameter int unsigned CHANNELS = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ld_i,
  input  logic [BITS-1:0] d_i [CHANNELS][DEPTH],
  output logic [BITS-1:0] q_o [CHANNELS][DEPTH]
);

  logic [BITS-1:0] mem_q [CHANNELS][DEPTH];
  logic [BITS-1:0] mem_d [CHANNELS][DEPTH];

  always_comb begin
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_d[c][i] = ld_i ? d_i[c][i] : mem_q[c][i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          mem_q[c][i] <= '0;
        end
      end
    end else begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          mem_q[c][i] <= mem_d[c][i];
        end
      end
    end
  end

  assign q_o = mem_q;

endmodule

// File: rtl/transpose_skew_buffer.sv
// Double-buffered matrix transposer: drains a loaded matrix as a diagonal skew,
// lane c lagging lane 0 by c steps, with a shadow bank for gapless back-to-back loads.
module transpose_skew_buffer
  import transpose_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned BITS     = 64,
  parameter int unsigned CHANNELS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [BITS-1:0]     ld_data [CHANNELS][DEPTH],
  input  logic                en,
  output logic                out_valid,
  output logic [CHANNELS-1:0] out_lane_valid,
  output logic [BITS-1:0]     out_data [CHANNELS],
  output logic                done
);

  localparam int unsigned SW = step_width(DEPTH, CHANNELS);
  localparam int unsigned DW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SW-1:0] LastStep = SW'(DEPTH + CHANNELS - 2);

  state_e          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic            shadow_full_q, shadow_full_d;
  logic            last_step;
  logic            act_ld, act_from_sh, sh_ld;
  logic [BITS-1:0] act_d [CHANNELS][DEPTH];
  logic [BITS-1:0] act_q [CHANNELS][DEPTH];
  logic [BITS-1:0] sh_q  [CHANNELS][DEPTH];

  always_comb begin
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        act_d[c][i] = act_from_sh ? sh_q[c][i] : ld_data[c][i];
      end
    end
  end

  transpose_bank #(
    .DEPTH   (DEPTH),
    .BITS    (BITS),
    .CHANNELS(CHANNELS)
  ) u_active (
    .clk  (clk),
    .rst_n(rst_n),
    .ld_i (act_ld),
    .d_i  (act_d),
    .q_o  (act_q)
  );

  transpose_bank #(
    .DEPTH   (DEPTH),
    .BITS    (BITS),
    .CHANNELS(CHANNELS)
  ) u_shadow (
    .clk  (clk),
    .rst_n(rst_n),
    .ld_i (sh_ld),
    .d_i  (ld_data),
    .q_o  (sh_q)
  );

  assign last_step = (s_q == LastStep);
  assign ld_ready  = !shadow_full_q;
  // The active bank holds a matrix exactly while draining.
  assign out_valid = (state_q == StDrain);

  always_comb begin
    state_d       = state_q;
    s_d           = s_q;
    shadow_full_d = shadow_full_q;
    act_ld        = 1'b0;
    act_from_sh   = 1'b0;
    sh_ld         = 1'b0;
    done          = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ld_valid) begin
          act_ld  = 1'b1;
          state_d = StDrain;
          s_d     = '0;
        end
      end
      StDrain: begin
        if (en && last_step) begin
          done = 1'b1;
          s_d  = '0;
          if (shadow_full_q) begin
            act_ld        = 1'b1;
            act_from_sh   = 1'b1;
            shadow_full_d = 1'b0;
          end else if (ld_valid) begin
            act_ld = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else begin
          if (en) begin
            s_d = s_q + SW'(1);
          end
          if (ld_valid && !shadow_full_q) begin
            sh_ld         = 1'b1;
            shadow_full_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      s_q           <= '0;
      shadow_full_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      s_q           <= s_d;
      shadow_full_q <= shadow_full_d;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    localparam logic [SW-1:0] LaneOfs = SW'(c);
    logic [SW-1:0] word_idx;
    logic          in_range;

    assign word_idx = s_q - LaneOfs;
    assign in_range = (state_q == StDrain) && (s_q >= LaneOfs) &&
                      (int'(word_idx) < int'(DEPTH));
    assign out_lane_valid[c] = in_range;
    assign out_data[c]       = in_range ? act_q[c][word_idx[DW-1:0]] : '0;
  end

endmodule
